// File: rtl/conv_sched.sv
// conv_sched: fetches a 64x64 Q4.16 image one pixel per cycle and streams two
// 3x3 convolutions (bias, round, ReLU) per output pixel in a fixed 12-cycle
// cadence per 2x2 output window. The window after the current one is prefetched
// into a second 4x4 patch while the current patch is being consumed.
module conv_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic [11:0] iaddr,
  input  logic [19:0] idata,
  output logic        o_valid,
  output logic [18:0] o_data
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  // kernel taps, index 3*dy+dx; entry [1] is K1, entry [0] is K0
  localparam logic [1:0][8:0][19:0] KW = {
    20'h05E68, 20'hFD369, 20'h03BD7, 20'h0202D, 20'h02F20,
    20'h050FD, 20'hFC994, 20'h02992, 20'hFDB55,
    20'hFAC19, 20'hFC834, 20'hFA6D7, 20'hF6E54, 20'hF8F71,
    20'h01004, 20'h06D43, 20'h092D5, 20'h0A89E};
  localparam logic [1:0][19:0] BW = {20'hF7295, 20'h01310};

  state_t                 state, state_d;
  logic [3:0]             phase, ph_d;
  logic [10:0]            win, win_d;      // window being fetched into nxt_p
  logic                   xfer, last;
  logic [4:0]             rp, cp;
  logic [6:0]             rowp1;           // fetch row + 1 (0 and 65 are padding)
  logic [5:0]             row, col;
  logic                   sl_act, sl_zero;
  logic [1:0]             sl_pr, sl_pc;
  logic [11:0]            sl_addr;
  logic                   wr_en, wr_zero;
  logic [1:0]             wr_pr, wr_pc;
  logic [3:0][3:0][19:0]  act_p, nxt_p, nxt_m, nxt_sh;
  logic [1:0]             ri, ci;
  logic [3:0]             kidx;
  logic [19:0]            pix, kc;
  logic signed [39:0]     prod;
  logic signed [43:0]     acc, rnd;
  logic                   unused_bits;

  // sequencing: next state, upcoming phase and upcoming fetch window
  always_comb begin
    state_d = state;
    ph_d    = 4'd0;
    win_d   = 11'd0;
    xfer    = (state != IDLE) && (phase == 4'd11);
    last    = (state == RUN) && xfer && (win == 11'd1024);
    case (state)
      IDLE:    if (ready) state_d = FILL;
      FILL:    if (xfer)  state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state != IDLE) begin
      ph_d  = xfer ? 4'd0 : phase + 4'd1;
      win_d = xfer ? win + 11'd1 : win;
    end
  end

  // decode the fetch slot that iaddr will present in the coming cycle
  always_comb begin
    rp      = win_d[9:5];
    cp      = win_d[4:0];
    rowp1   = {1'b0, rp, 1'b0} + {5'd0, ph_d[1:0]};
    sl_zero = (rowp1 == 7'd0) || (rowp1 == 7'd65);
    sl_pr   = ph_d[1:0];
    if (cp == 5'd0) begin
      sl_act = ph_d < 4'd12;
      sl_pc  = ph_d[3:2] + 2'd1;
      col    = {4'd0, ph_d[3:2]};
    end else begin
      sl_act = ph_d < ((cp == 5'd31) ? 4'd4 : 4'd8);
      sl_pc  = {1'b1, ph_d[2]};
      col    = {cp, 1'b1} + {5'd0, ph_d[2]};
    end
    if (state_d == IDLE || win_d[10]) sl_act = 1'b0;
    row     = rowp1[5:0] - 6'd1;
    sl_addr = sl_zero ? 12'd0 : {row, col};
  end

  // next patch with the pixel arriving this cycle merged in, and its left shift
  always_comb begin
    nxt_m = nxt_p;
    if (wr_en) nxt_m[wr_pr][wr_pc] = wr_zero ? 20'd0 : idata;
    nxt_sh = '0;
    for (int r = 0; r < 4; r++) begin
      nxt_sh[r][0] = nxt_m[r][2];
      nxt_sh[r][1] = nxt_m[r][3];
    end
  end

  // 3x3 MAC for output pixel (phase[1], phase[2]) with kernel phase[0]
  always_comb begin
    acc  = {{8{BW[phase[0]][19]}}, BW[phase[0]], 16'd0};
    prod = '0;
    pix  = '0;
    kc   = '0;
    ri   = '0;
    ci   = '0;
    kidx = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ri   = 2'(i) + {1'b0, phase[1]};
        ci   = 2'(j) + {1'b0, phase[2]};
        kidx = 4'(3 * i + j);
        pix  = act_p[ri][ci];
        kc   = KW[phase[0]][kidx];
        prod = $signed(pix) * $signed(kc);
        acc  = acc + 44'(prod);
      end
    end
    rnd = acc + 44'sd32768;
  end

  // result keeps only bits 34:16 of the rounded sum
  assign unused_bits = ^{rnd[43:35], rnd[15:0]};

  // state, fetch, patch and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      win     <= '0;
      busy    <= 1'b0;
      iaddr   <= '0;
      wr_en   <= 1'b0;
      wr_zero <= 1'b0;
      wr_pr   <= '0;
      wr_pc   <= '0;
      act_p   <= '0;
      nxt_p   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      state   <= state_d;
      phase   <= ph_d;
      win     <= win_d;
      busy    <= (state_d != IDLE);
      wr_en   <= sl_act;
      wr_zero <= sl_zero;
      wr_pr   <= sl_pr;
      wr_pc   <= sl_pc;
      if (sl_act) iaddr <= sl_addr;
      if (state == IDLE) nxt_p <= '0;
      else if (xfer) begin
        act_p <= nxt_m;
        nxt_p <= (win_d[4:0] == 5'd0) ? '0 : nxt_sh;
      end else nxt_p <= nxt_m;
      o_valid <= (state == RUN) && (phase < 4'd8);
      o_data  <= ((state == RUN) && (phase < 4'd8) && !acc[43]) ? rnd[34:16] : '0;
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: image memory answers iaddr, a scoreboard queue holds
// (cycle, value) for every expected strobe, a monitor pops and compares, and a
// fetch checker follows the expected iaddr slot schedule.
module tb_conv_sched;
  logic        clk = 1'b0;
  logic        reset, ready, busy, o_valid;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic [18:0] o_data;

  typedef struct {int t; logic [18:0] d;} exp_t;
  exp_t        sbq[$];
  logic [19:0] img [4096];
  int          fcnt [4096];
  logic [19:0] k0t [9] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                           20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};
  logic [19:0] k1t [9] = '{20'hFDB55, 20'h02992, 20'hFC994, 20'h050FD, 20'h02F20,
                           20'h0202D, 20'h03BD7, 20'hFD369, 20'h05E68};
  int          cyc = 0, t0 = 0, checks = 0, errors = 0;
  logic        run_on = 1'b0;
  logic [11:0] prev_iaddr = '0;

  conv_sched dut (.clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
                  .idata(idata), .o_valid(o_valid), .o_data(o_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign idata = img[iaddr];

  function automatic longint sx(input logic [19:0] v);
    return longint'($signed(v));
  endfunction

  // straightforward zero-padded convolution of the bench image
  function automatic logic [18:0] golden(input int r, input int c, input int k);
    longint s, p;
    int rr, cc;
    s = (k != 0 ? sx(20'hF7295) : sx(20'h01310)) * 65536;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        rr = r + dy - 1;
        cc = c + dx - 1;
        p = (rr < 0 || rr > 63 || cc < 0 || cc > 63) ? 0 : sx(img[rr * 64 + cc]);
        s += p * (k != 0 ? sx(k1t[3 * dy + dx]) : sx(k0t[3 * dy + dx]));
      end
    if (s < 0) return '0;
    s = (s + 32768) / 65536;
    return s[18:0];
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // mode 0: zero image, 1: constant 1.0 image, 2: model only
  task automatic push_run(input int mode);
    for (int w = 0; w < 1024; w++)
      for (int j = 0; j < 8; j++) begin
        int r, c, k;
        exp_t e;
        k = j & 1;
        r = 2 * (w >> 5) + ((j >> 1) & 1);
        c = 2 * (w & 31) + ((j >> 2) & 1);
        e.t = t0 + 14 + 12 * w + j;
        if (mode == 0) e.d = (k != 0) ? 19'h0 : 19'h01310;
        else if (mode == 1 && r > 0 && r < 63 && c > 0 && c < 63)
          e.d = (k != 0) ? 19'h04F02 : 19'h0;
        else if (mode == 1 && r == 0 && c == 0) e.d = 19'h0;
        else e.d = golden(r, c, k);
        sbq.push_back(e);
      end
  endtask

  task automatic start_run(input int mode);
    @(negedge clk);
    ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4096; i++) fcnt[i] = 0;
    push_run(mode);
    run_on = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 13000);
    chk("busy_fall_cycle", cyc - t0, 12301);
    chk("stream_left", sbq.size(), 0);
    run_on = 1'b0;
    sbq.delete();
  endtask

  // monitor: every strobe pops one expected (cycle, value)
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL stream_extra cyc=%0d got %0h", cyc - t0, o_data);
      end else begin
        e = sbq.pop_front();
        if (cyc != e.t || o_data !== e.d) begin
          errors++;
          $display("FAIL stream cyc got %0d want %0d data got %0h want %0h",
                   cyc - t0, e.t - t0, o_data, e.d);
        end
      end
    end else if (o_data !== 19'd0) begin
      checks++;
      errors++;
      $display("FAIL odata_idle got %0h want 0", o_data);
    end
  end

  // fetch checker: expected slot addresses and held iaddr on idle slots
  always @(negedge clk) begin
    int t, wp, s, rp, cp, nact, row, col, ea;
    if (run_on) begin
      t = cyc - t0;
      if (t >= 1 && t <= 12288) begin
        if (t <= 12) begin wp = 0; s = t - 1; end
        else begin wp = (t - 13) / 12 + 1; s = (t - 13) % 12; end
        rp   = wp >> 5;
        cp   = wp & 31;
        nact = (cp == 0) ? 12 : (cp == 31) ? 4 : 8;
        row  = 2 * rp - 1 + (s % 4);
        col  = (cp == 0) ? s / 4 : 2 * cp + 1 + s / 4;
        checks++;
        if (s < nact) begin
          ea = (row < 0 || row > 63) ? 0 : row * 64 + col;
          if (iaddr !== 12'(ea)) begin
            errors++;
            $display("FAIL iaddr cyc=%0d got %0h want %0h", t, iaddr, ea);
          end
          if (row >= 0 && row <= 63) fcnt[ea]++;
        end else if (iaddr !== prev_iaddr) begin
          errors++;
          $display("FAIL iaddr_hold cyc=%0d got %0h want %0h", t, iaddr, prev_iaddr);
        end
      end
    end
    prev_iaddr = iaddr;
  end

  initial begin
    int mx, mn;
    reset = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ready = 1'($urandom);
    end
    chk("rst_busy", busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_odata", o_data, 0);
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", o_valid, 0);

    // zero image, with ready pulses during the run that must be ignored
    for (int i = 0; i < 4096; i++) img[i] = 20'h0;
    start_run(0);
    foreach (sbq[i]) ;
    for (int p = 0; p < 4; p++) begin
      int tgt;
      tgt = (p == 0) ? 5 : (p == 1) ? 300 : (p == 2) ? 6000 : 12290;
      while (cyc - t0 < tgt) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    wait_end();

    // constant 1.0 image, started right after the previous stream
    for (int i = 0; i < 4096; i++) img[i] = 20'h10000;
    start_run(1);
    wait_end();

    // random image against the model, plus fetch multiplicity
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    start_run(2);
    wait_end();
    mx = 0;
    mn = 99;
    for (int i = 0; i < 4096; i++) begin
      if (fcnt[i] > mx) mx = fcnt[i];
      if (fcnt[i] < mn) mn = fcnt[i];
    end
    chk("fetch_max_le2", (mx <= 2), 1);
    chk("fetch_min_ge1", (mn >= 1), 1);

    // reset in period 500 phase 3, then a fresh full run
    start_run(2);
    while (cyc - t0 < 13 + 12 * 500 + 3) @(negedge clk);
    #1 reset = 1'b0;
    run_on = 1'b0;
    sbq.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_iaddr", iaddr, 0);
    chk("abort_odata", o_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_run(2);
    wait_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
